dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 35 +++
 rtl/dmem_wait_cnt.sv | 30 +++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Shared definitions for the data-memory responder: MEM-stage request codes,
// bus widths, zero constants, wait-counter width and FSM state encoding.
package dmem_responder_pkg;

    // Bus widths
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    // Wait counter width; it must hold WAIT_CYCLES-1 for WAIT_CYCLES up to 15
    localparam int CNT_W = 4;

    // Request codes on mem_memrw; 2'b11 is not a request and behaves as idle
    localparam logic [1:0] MEMRW_IDLE  = 2'b00;
    localparam logic [1:0] MEMRW_READ  = 2'b01;
    localparam logic [1:0] MEMRW_WRITE = 2'b10;

    // Zero constants
    localparam logic [DATA_W-1:0] ZERO_DATA = '0;
    localparam logic [CNT_W-1:0]  ZERO_CNT  = '0;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } dmem_state_t;

    // True for a real read or write request
    function automatic logic is_request(input logic [1:0] memrw);
        return (memrw == MEMRW_READ) || (memrw == MEMRW_WRITE);
    endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// dmem_wait_cnt
// Access-phase wait counter: parallel load, decrement (saturating at zero)
// and a combinational zero flag used by the responder FSM to leave ACCESS.
module dmem_wait_cnt
    import dmem_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_reg;

    // Load has priority; decrement stops at zero so the flag stays stable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= ZERO_CNT;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != ZERO_CNT)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == ZERO_CNT);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// MEM-stage data-memory responder for an asynchronous SRAM. A read or write
// seen in IDLE is captured and run through SETUP -> ACCESS (WAIT_CYCLES) ->
// DONE while the pipeline is held by mem_stall. All SRAM strobes are
// registered and computed from the state being entered.
// Optional build macro: DMEM_ALIGN_CHK_EN -- rejects requests whose byte
// address is not word aligned with a one-cycle mem_err pulse.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mem_memrw,
    input  logic [ADDR_W-1:0]  mem_memaddr,
    input  logic [DATA_W-1:0]  mem_memdata,
    output logic [DATA_W-1:0]  mem_rdata,
    output logic               mem_stall,
    output logic               mem_err,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [DATA_W-1:0]  sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    dmem_state_t state_reg;
    logic        write_reg;
    logic        request;
    logic        misaligned;
    logic        accept;
    logic        cnt_zero;
    logic        unused_addr_bits;

    assign request = is_request(mem_memrw);

`ifdef DMEM_ALIGN_CHK_EN
    assign misaligned = |mem_memaddr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Byte-lane and upper address bits never reach the word-addressed SRAM
    assign unused_addr_bits = ^{mem_memaddr[ADDR_W-1:SRAM_AW+2], mem_memaddr[1:0]};

    assign accept = (state_reg == ST_IDLE) && request && !misaligned;

    // Stall must rise in the request cycle itself, so it is decoded from state
    assign mem_stall = accept || (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);

    dmem_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state_reg == ST_SETUP),
        .load_val (CNT_W'(WAIT_CYCLES - 1)),
        .dec      (state_reg == ST_ACCESS),
        .zero     (cnt_zero)
    );

    // FSM with request capture, read-data register and registered SRAM strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            write_reg  <= 1'b0;
            mem_rdata  <= ZERO_DATA;
            sram_addr  <= '0;
            sram_dq_o  <= ZERO_DATA;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= ST_SETUP;
                        write_reg <= (mem_memrw == MEMRW_WRITE);
                        sram_addr <= mem_memaddr[SRAM_AW+1:2];
                        sram_dq_o <= mem_memdata;
                        sram_ce_n <= 1'b0;
                        // Writes drive the bus from SETUP; reads enable the SRAM output
                        if (mem_memrw == MEMRW_WRITE) begin
                            sram_dq_oe <= 1'b1;
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                    end
                end
                ST_SETUP: begin
                    state_reg <= ST_ACCESS;
                    // WE pulse starts one cycle after address/data are stable
                    if (write_reg) begin
                        sram_we_n <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        state_reg <= ST_DONE;
                        if (write_reg) begin
                            // Release WE but keep CE and data for one hold cycle
                            sram_we_n <= 1'b1;
                        end else begin
                            sram_ce_n <= 1'b1;
                            sram_oe_n <= 1'b1;
                            mem_rdata <= sram_dq_i;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg  <= ST_IDLE;
                    sram_ce_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ALIGN_CHK_EN
    // One-cycle error pulse for a misaligned request seen in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= (state_reg == ST_IDLE) && request && misaligned;
        end
    end
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Scoreboarded bench for dmem_responder: two instances (WAIT_CYCLES=2 and 1)
// share the request and SRAM read-data inputs. Honours DMEM_ALIGN_CHK_EN.
module tb_dmem_responder;

    localparam int W1 = 2;
    localparam int W2 = 1;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;
    localparam logic [1:0] ID = 2'b00;

    logic        clk;
    logic        rst;
    logic [1:0]  memrw;
    logic [31:0] memaddr;
    logic [31:0] memdata;
    logic [31:0] dq_i;

    logic [31:0] rdata1, dq_o1, rdata2, dq_o2;
    logic [19:0] addr1, addr2;
    logic        stall1, err1, dq_oe1, ce1, oe1, we1;
    logic        stall2, err2, dq_oe2, ce2, oe2, we2;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] model_rdata1;

    dmem_responder #(.WAIT_CYCLES(W1), .SRAM_AW(20)) u_dut1 (
        .clk(clk), .rst(rst), .mem_memrw(memrw), .mem_memaddr(memaddr),
        .mem_memdata(memdata), .mem_rdata(rdata1), .mem_stall(stall1),
        .mem_err(err1), .sram_addr(addr1), .sram_dq_o(dq_o1),
        .sram_dq_oe(dq_oe1), .sram_dq_i(dq_i), .sram_ce_n(ce1),
        .sram_oe_n(oe1), .sram_we_n(we1)
    );

    dmem_responder #(.WAIT_CYCLES(W2), .SRAM_AW(20)) u_dut2 (
        .clk(clk), .rst(rst), .mem_memrw(memrw), .mem_memaddr(memaddr),
        .mem_memdata(memdata), .mem_rdata(rdata2), .mem_stall(stall2),
        .mem_err(err2), .sram_addr(addr2), .sram_dq_o(dq_o2),
        .sram_dq_oe(dq_oe2), .sram_dq_i(dq_i), .sram_ce_n(ce2),
        .sram_oe_n(oe2), .sram_we_n(we2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drain a few idle cycles so both instances are back in IDLE
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            memrw = ID;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; memrw = ID; memaddr = '0; memdata = '0; dq_i = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++; $display("FAIL reset_rdata actual=%h required=%h", rdata1, 32'h0);
        end
        checks++;
        if ({ce1, oe1, we1, dq_oe1} !== 4'b1110) begin
            errors++; $display("FAIL reset_strobes actual=%b required=%b", {ce1, oe1, we1, dq_oe1}, 4'b1110);
        end
        checks++;
        if ({addr1, dq_o1} !== 52'h0) begin
            errors++; $display("FAIL reset_addr_data actual=%h required=%h", {addr1, dq_o1}, 52'h0);
        end
        checks++;
        if ({stall1, err1} !== 2'b00) begin
            errors++; $display("FAIL reset_stall_err actual=%b required=%b", {stall1, err1}, 2'b00);
        end
        model_rdata1 = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        $display("txn reset done");
    endtask

    // Single access on instance 1, checked cycle by cycle against the timeline:
    // c=0 IDLE+request, c=1 SETUP, c=2..W1+1 ACCESS, c=W1+2 DONE, c=W1+3 IDLE
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] dq);
        logic [3:0]  exp_strb;
        logic        ce_act, we_act;
        logic [31:0] popped;
        bit          done_seen;
        done_seen = 1'b0;
        if (op == RD) model_rdata1 = dq;
        sb_q.push_back(model_rdata1);
        for (int c = 0; c <= W1 + 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                memrw = op; memaddr = addr; memdata = data; dq_i = dq;
            end else begin
                memrw = ID; memaddr = ~addr; memdata = ~data;
            end
            #1;
            checks++;
            if (stall1 !== (c <= W1 + 1)) begin
                errors++; $display("FAIL %s_stall c=%0d actual=%b required=%b", name, c, stall1, (c <= W1 + 1));
            end
            if (op == RD) begin
                exp_strb = (c >= 1 && c <= W1 + 1) ? 4'b0010 : 4'b1110;
            end else begin
                ce_act = (c >= 1 && c <= W1 + 2);
                we_act = (c >= 2 && c <= W1 + 1);
                exp_strb = {~ce_act, 1'b1, ~we_act, ce_act};
            end
            checks++;
            if ({ce1, oe1, we1, dq_oe1} !== exp_strb) begin
                errors++; $display("FAIL %s_strobes c=%0d actual=%b required=%b", name, c, {ce1, oe1, we1, dq_oe1}, exp_strb);
            end
            if (c >= 1 && c <= W1 + 2) begin
                checks++;
                if (addr1 !== addr[21:2]) begin
                    errors++; $display("FAIL %s_sram_addr c=%0d actual=%h required=%h", name, c, addr1, addr[21:2]);
                end
                if (op == WR) begin
                    checks++;
                    if (dq_o1 !== data) begin
                        errors++; $display("FAIL %s_dq_o c=%0d actual=%h required=%h", name, c, dq_o1, data);
                    end
                end
            end
            checks++;
            if (err1 !== 1'b0) begin
                errors++; $display("FAIL %s_err c=%0d actual=%b required=0", name, c, err1);
            end
            if (!done_seen && c > 0 && stall1 === 1'b0) begin
                done_seen = 1'b1;
                popped = sb_q.pop_front();
                checks++;
                if (c != W1 + 2) begin
                    errors++; $display("FAIL %s_latency actual=%0d required=%0d", name, c, W1 + 2);
                end
                checks++;
                if (rdata1 !== popped) begin
                    errors++; $display("FAIL %s_rdata actual=%h required=%h", name, rdata1, popped);
                end
            end
        end
        if (!done_seen) begin
            checks++; errors++;
            $display("FAIL %s_completion actual=none required=stall release", name);
            sb_q.delete();
        end
        $display("txn %s op=%b addr=%h data=%h rdata=%h", name, op, addr, data, rdata1);
        idle_cycles(2);
    endtask

    task automatic test_read();
        run_op("read", RD, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
    endtask

    task automatic test_write();
        run_op("write", WR, 32'h0000_0020, 32'h1234_5678, 32'h5555_AAAA);
    endtask

    task automatic test_invalid_code();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            memrw = (c == 0) ? 2'b11 : ID;
            memaddr = 32'h0000_0030;
            #1;
            checks++;
            if ({stall1, stall2} !== 2'b00) begin
                errors++; $display("FAIL code11_stall c=%0d actual=%b required=00", c, {stall1, stall2});
            end
            checks++;
            if ({ce1, oe1, we1, dq_oe1, ce2, oe2, we2, dq_oe2} !== 8'b1110_1110) begin
                errors++; $display("FAIL code11_strobes c=%0d actual=%b required=11101110", c, {ce1, oe1, we1, dq_oe1, ce2, oe2, we2, dq_oe2});
            end
        end
        $display("txn code11 no access");
    endtask

    // Read held through its stall, then a write presented after the DONE cycle
    task automatic test_back_to_back();
        logic        exp_stall, prev_stall, prev_ce;
        int          falls, starts;
        logic [31:0] popped;
        falls = 0; starts = 0; prev_stall = 1'b0; prev_ce = 1'b1;
        model_rdata1 = 32'hCAFE_F00D;
        sb_q.push_back(model_rdata1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                memrw = RD; memaddr = 32'h0000_0040; memdata = 32'h0; dq_i = 32'hCAFE_F00D;
            end else if (c <= 9) begin
                memrw = WR; memaddr = 32'h0000_0044; memdata = 32'hA5A5_5A5A;
            end else begin
                memrw = ID;
            end
            if (c == 5) sb_q.push_back(model_rdata1);
            #1;
            exp_stall = (c <= 3) || (c >= 5 && c <= 8);
            checks++;
            if (stall1 !== exp_stall) begin
                errors++; $display("FAIL b2b_stall c=%0d actual=%b required=%b", c, stall1, exp_stall);
            end
            if (prev_stall && !stall1) begin
                falls++;
                popped = sb_q.pop_front();
                checks++;
                if (rdata1 !== popped) begin
                    errors++; $display("FAIL b2b_rdata c=%0d actual=%h required=%h", c, rdata1, popped);
                end
            end
            if (prev_ce && !ce1) starts++;
            if (c == 7) begin
                checks++;
                if ({we1, addr1, dq_o1} !== {1'b0, 20'h00011, 32'hA5A5_5A5A}) begin
                    errors++; $display("FAIL b2b_write_phase actual=%b/%h/%h required=0/00011/a5a55a5a", we1, addr1, dq_o1);
                end
            end
            prev_stall = stall1;
            prev_ce = ce1;
        end
        checks++;
        if (falls != 2 || starts != 2) begin
            errors++; $display("FAIL b2b_access_count actual=%0d/%0d required=2/2", falls, starts);
        end
        if (sb_q.size() != 0) sb_q.delete();
        $display("txn back_to_back accesses=%0d", starts);
        idle_cycles(4);
    endtask

    // WAIT_CYCLES=1 read on instance 2: stall cycles 0..2, data at cycle 3
    task automatic test_wait1();
        logic [31:0] popped;
        bit          done_seen;
        done_seen = 1'b0;
        sb_q.push_back(32'h0BAD_CAFE);
        model_rdata1 = 32'h0BAD_CAFE;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                memrw = RD; memaddr = 32'h0000_0050; dq_i = 32'h0BAD_CAFE;
            end else begin
                memrw = ID;
            end
            #1;
            checks++;
            if (stall2 !== (c <= 2)) begin
                errors++; $display("FAIL wait1_stall c=%0d actual=%b required=%b", c, stall2, (c <= 2));
            end
            checks++;
            if ({ce2, oe2, we2, dq_oe2} !== ((c >= 1 && c <= 2) ? 4'b0010 : 4'b1110)) begin
                errors++; $display("FAIL wait1_strobes c=%0d actual=%b", c, {ce2, oe2, we2, dq_oe2});
            end
            if (!done_seen && c > 0 && stall2 === 1'b0) begin
                done_seen = 1'b1;
                popped = sb_q.pop_front();
                checks++;
                if (c != 3 || rdata2 !== popped) begin
                    errors++; $display("FAIL wait1_data c=%0d actual=%h required=%h at c=3", c, rdata2, popped);
                end
            end
        end
        if (!done_seen) begin
            checks++; errors++;
            $display("FAIL wait1_completion actual=none required=stall release");
            sb_q.delete();
        end
        $display("txn wait1 read rdata=%h", rdata2);
        idle_cycles(2);
    endtask

    task automatic test_misaligned();
`ifdef DMEM_ALIGN_CHK_EN
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            memrw = (c == 0) ? RD : ID;
            memaddr = 32'h0000_0013;
            #1;
            checks++;
            if (err1 !== (c == 1)) begin
                errors++; $display("FAIL misaligned_err c=%0d actual=%b required=%b", c, err1, (c == 1));
            end
            checks++;
            if ({stall1, ce1, oe1, we1, dq_oe1} !== 5'b01110) begin
                errors++; $display("FAIL misaligned_quiet c=%0d actual=%b required=01110", c, {stall1, ce1, oe1, we1, dq_oe1});
            end
        end
        $display("txn misaligned rejected");
`else
        run_op("misaligned", RD, 32'h0000_0013, 32'h0, 32'h7766_5544);
`endif
    endtask

    // Reset asserted in the ACCESS phase of a write aborts it at once
    task automatic test_reset_mid_write();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                memrw = WR; memaddr = 32'h0000_0020; memdata = 32'h1234_5678;
            end else begin
                memrw = ID;
            end
        end
        #1;
        checks++;
        if ({ce1, we1} !== 2'b00) begin
            errors++; $display("FAIL midrst_in_access actual=%b required=00", {ce1, we1});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ce1, oe1, we1, dq_oe1} !== 4'b1110) begin
            errors++; $display("FAIL midrst_strobes actual=%b required=1110", {ce1, oe1, we1, dq_oe1});
        end
        checks++;
        if (rdata1 !== 32'h0 || stall1 !== 1'b0) begin
            errors++; $display("FAIL midrst_state actual=%h/%b required=0/0", rdata1, stall1);
        end
        model_rdata1 = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        $display("txn reset mid write");
        run_op("post_reset_read", RD, 32'h0000_0100, 32'h0, 32'h1357_9BDF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_invalid_code();
        test_back_to_back();
        test_wait1();
        test_misaligned();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
